// File: rtl/jsn_pkg.sv
// Shared types and helpers for the Johnson phase sequencer.
// jsn_next is width-generic so the top can use it for any WIDTH up to 32.
package jsn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } jsn_state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    // Next Johnson code for a register of 'width' bits held in the low bits of cur.
    function automatic logic [31:0] jsn_next(input logic [31:0] cur,
                                             input int          width,
                                             input logic        dir);
        logic [31:0] mask;
        logic [31:0] msb_v;
        logic [31:0] nxt;
        mask  = (width >= 32) ? '1 : ((32'h1 << width) - 32'h1);
        msb_v = cur >> (width - 1);
        if (dir == DIR_FWD) begin
            nxt = ((cur << 1) | {31'b0, ~msb_v[0]}) & mask;
        end else begin
            nxt = (cur >> 1) | ({31'b0, ~cur[0]} << (width - 1));
        end
        return nxt;
    endfunction

endpackage

// File: rtl/jsn_rate_div.sv
// Reloadable down-counter that paces phase steps.
// tick is high while the count is zero; the counter reloads on the enabled tick cycle.
module jsn_rate_div #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    input  logic             en,
    input  logic [DIV_W-1:0] reload_val,
    output logic             tick
);

    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = (count_q == '0) ? reload_val : count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = (count_q == '0);

endmodule

// File: rtl/jsn_phase_ctrl.sv
// Command-driven Johnson phase sequencer: steps a retained phase register
// a programmed number of times at a programmed rate, with pause and abort.
module jsn_phase_ctrl
    import jsn_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             cmd_dir,
    input  logic [DIV_W-1:0] cmd_div,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] phase,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] steps_left
);

    jsn_state_t       state_q, state_d;
    logic [WIDTH-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] steps_left_q, steps_left_d;
    logic             dir_q, dir_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             aborted_q, aborted_d;

    logic             div_load;
    logic             div_en;
    logic             div_tick;
    logic [31:0]      next_full;
    logic [WIDTH-1:0] phase_step;

    jsn_rate_div #(.DIV_W(DIV_W)) u_rate_div (
        .clk        (clk),
        .rst        (rst),
        .load       (div_load),
        .load_val   (cmd_div),
        .en         (div_en),
        .reload_val (div_q),
        .tick       (div_tick)
    );

    always_comb begin
        next_full  = jsn_next(32'(phase_q), WIDTH, dir_q);
        phase_step = next_full[WIDTH-1:0];
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        steps_left_d = steps_left_q;
        dir_d        = dir_q;
        div_d        = div_q;
        aborted_d    = aborted_q;
        div_load     = 1'b0;
        div_en       = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    dir_d        = cmd_dir;
                    div_d        = cmd_div;
                    steps_left_d = cmd_steps;
                    aborted_d    = 1'b0;
                    div_load     = 1'b1;
                    state_d      = (cmd_steps == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                end else if (!pause) begin
                    // Divider runs only here, so pause and abort freeze it too.
                    div_en = 1'b1;
                    if (div_tick) begin
                        phase_d = phase_step;
                        if (steps_left_q != '0) begin
                            steps_left_d = steps_left_q - 1'b1;
                        end
                        if (steps_left_q <= CNT_W'(1)) begin
                            state_d   = DONE;
                            aborted_d = 1'b0;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            steps_left_q <= '0;
            dir_q        <= DIR_FWD;
            div_q        <= '0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            steps_left_q <= steps_left_d;
            dir_q        <= dir_d;
            div_q        <= div_d;
            aborted_q    <= aborted_d;
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign aborted    = aborted_q;
    assign phase      = phase_q;
    assign steps_left = steps_left_q;

endmodule
